// File: rtl/cam_pixel_binarizer_pkg.sv
// Shared constants and types for the camera front end: frame geometry,
// BT.601-style luma weights and the RGB565 field layout.
package cam_pixel_binarizer_pkg;

    localparam int FRAME_SIZE = 76800;
    localparam int ADDR_W     = 17;

    localparam logic [7:0] COEF_R     = 8'd77;
    localparam logic [7:0] COEF_G     = 8'd150;
    localparam logic [7:0] COEF_B     = 8'd29;
    localparam int         LUMA_SHIFT = 8;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic rgb565_t unpack565(input logic [15:0] w);
        rgb565_t p;
        p.r = w[R_MSB:R_LSB];
        p.g = w[G_MSB:G_LSB];
        p.b = w[B_MSB:B_LSB];
        return p;
    endfunction

endpackage

// File: rtl/cam_pixel_binarizer_if.sv
// Camera byte stream in, binarised capture write stream out.
interface cam_pixel_binarizer_if;
    import cam_pixel_binarizer_pkg::*;

    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_byte;
    logic              cam_byte_valid;
    logic              capture_pixel;
    logic [ADDR_W-1:0] capture_addr;
    logic              capture_wren;

    modport master (
        output cam_vsync, cam_href, cam_byte, cam_byte_valid,
        input  capture_pixel, capture_addr, capture_wren
    );

    modport slave (
        input  cam_vsync, cam_href, cam_byte, cam_byte_valid,
        output capture_pixel, capture_addr, capture_wren
    );

endinterface

// File: rtl/cam_pixel_binarizer_luma_pipe.sv
// Two-stage RGB565 -> 8-bit luma: expand and multiply, then sum and shift.
module rgb565_luma_pipe
    import cam_pixel_binarizer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_vld,
    input  rgb565_t    in_pix,
    output logic       out_vld,
    output logic [7:0] out_luma
);

    logic [2:1]  vld_pipe_d, vld_pipe_q;
    logic [7:0]  r8, g8, b8;
    logic [15:0] prod_r_d, prod_g_d, prod_b_d;
    logic [15:0] prod_r_q, prod_g_q, prod_b_q;
    logic [15:0] sum;
    logic [7:0]  luma_d, luma_q;

    // Bit replication maps full-scale 5/6-bit codes to exactly 255.
    always_comb begin
        r8         = {in_pix.r, in_pix.r[4:2]};
        g8         = {in_pix.g, in_pix.g[5:4]};
        b8         = {in_pix.b, in_pix.b[4:2]};
        prod_r_d   = {8'd0, r8} * {8'd0, COEF_R};
        prod_g_d   = {8'd0, g8} * {8'd0, COEF_G};
        prod_b_d   = {8'd0, b8} * {8'd0, COEF_B};
        sum        = prod_r_q + prod_g_q + prod_b_q;
        luma_d     = 8'(sum >> LUMA_SHIFT);
        vld_pipe_d = {vld_pipe_q[1], in_vld};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            prod_r_q   <= '0;
            prod_g_q   <= '0;
            prod_b_q   <= '0;
            luma_q     <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            prod_r_q   <= prod_r_d;
            prod_g_q   <= prod_g_d;
            prod_b_q   <= prod_b_d;
            luma_q     <= luma_d;
        end
    end

    assign out_vld  = vld_pipe_q[2];
    assign out_luma = luma_q;

endmodule

// File: rtl/cam_pixel_binarizer.sv
// OV7670 RGB565 byte stream -> thresholded 1-bit pixels with frame addressing,
// frame-done pulse and frame-size error status.
module cam_pixel_binarizer #(
    parameter int FRAME_SIZE = cam_pixel_binarizer_pkg::FRAME_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    cam_pixel_binarizer_if.slave  cam,
    input  logic [7:0]            bin_thres,
    input  logic                  invert,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic [7:0]            luma_out
);
    import cam_pixel_binarizer_pkg::*;

    localparam logic [ADDR_W-1:0] FS_W = ADDR_W'(FRAME_SIZE);

    logic              vsync_q, href_q;
    logic              armed_d, armed_q;
    logic              phase_d, phase_q;
    logic [7:0]        byte0_d, byte0_q;
    logic [ADDR_W-1:0] count_d, count_q, last_count_d, last_count_q;
    logic [ADDR_W-1:0] addr1_d, addr1_q, addr2_q;
    logic [1:0]        done_sr_d, done_sr_q;
    logic              frame_done_d, frame_done_q, frame_error_d, frame_error_q;
    logic              pixel_d, pixel_q, wren_d, wren_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [7:0]        luma_d, luma_q;
    logic              vsync_rise, href_fall, accept, pix_vld, hit;
    rgb565_t           pix;
    logic              pipe_vld;
    logic [7:0]        pipe_luma;

    rgb565_luma_pipe u_luma (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (pix_vld),
        .in_pix   (pix),
        .out_vld  (pipe_vld),
        .out_luma (pipe_luma)
    );

    always_comb begin
        vsync_rise = cam.cam_vsync & ~vsync_q;
        href_fall  = href_q & ~cam.cam_href;
        accept     = cam.cam_byte_valid & cam.cam_href & ~cam.cam_vsync & armed_q;
        pix_vld    = accept & phase_q;
        pix        = unpack565({byte0_q, cam.cam_byte});

        armed_d      = vsync_rise ? enable : armed_q;
        phase_d      = phase_q;
        byte0_d      = byte0_q;
        count_d      = count_q;
        last_count_d = last_count_q;
        addr1_d      = pix_vld ? count_q : addr1_q;

        if (accept) begin
            phase_d = ~phase_q;
            if (!phase_q) byte0_d = cam.cam_byte;
        end
        // Keep counting past the frame end so oversize frames still flag.
        if (pix_vld && count_q != '1) count_d = count_q + 1'b1;
        if (vsync_rise || href_fall) phase_d = 1'b0;
        if (vsync_rise) begin
            count_d      = '0;
            last_count_d = count_q;
        end

        // Done is delayed past the pipe depth so it trails the frame's last write.
        done_sr_d     = {done_sr_q[0], vsync_rise & armed_q};
        frame_done_d  = done_sr_q[1];
        frame_error_d = done_sr_q[1] ? (last_count_q != FS_W) : frame_error_q;

        hit     = (pipe_luma >= bin_thres) ^ invert;
        wren_d  = pipe_vld && (addr2_q < FS_W);
        pixel_d = wren_d ? hit : pixel_q;
        addr_d  = wren_d ? addr2_q : addr_q;
        luma_d  = wren_d ? pipe_luma : luma_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            armed_q       <= 1'b0;
            phase_q       <= 1'b0;
            byte0_q       <= '0;
            count_q       <= '0;
            last_count_q  <= '0;
            addr1_q       <= '0;
            addr2_q       <= '0;
            done_sr_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            pixel_q       <= 1'b0;
            wren_q        <= 1'b0;
            addr_q        <= '0;
            luma_q        <= '0;
        end else begin
            vsync_q       <= cam.cam_vsync;
            href_q        <= cam.cam_href;
            armed_q       <= armed_d;
            phase_q       <= phase_d;
            byte0_q       <= byte0_d;
            count_q       <= count_d;
            last_count_q  <= last_count_d;
            addr1_q       <= addr1_d;
            addr2_q       <= addr1_q;
            done_sr_q     <= done_sr_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            pixel_q       <= pixel_d;
            wren_q        <= wren_d;
            addr_q        <= addr_d;
            luma_q        <= luma_d;
        end
    end

    assign cam.capture_pixel = pixel_q;
    assign cam.capture_addr  = addr_q;
    assign cam.capture_wren  = wren_q;
    assign frame_done        = frame_done_q;
    assign frame_error       = frame_error_q;
    assign luma_out          = luma_q;

endmodule

// File: doc/cam_pixel_binarizer.md
Name: cam_pixel_binarizer

Overview:
- Upstream stage of the suspicious-object detector.
- Accepts the OV7670 RGB565 byte stream, already synchronised into the system clock domain, and assembles pixels.
- Converts each pixel to 8-bit luma and thresholds it to 1-bit black/white.
- Emits the capture_pixel / capture_addr / capture_wren stream the detector consumes; also reports frame completion and frame-size errors.

Parameters:
- FRAME_SIZE, 76800: pixels per frame (320x240); the address range is 0..FRAME_SIZE-1.
- ADDR_W, 17: width of capture_addr and of the internal pixel counter.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; sampled only at frame boundaries.
- cam_vsync  in  1  camera VSYNC; high = vertical blanking.
- cam_href  in  1  camera HREF; high = active line bytes.
- cam_byte  in  8  camera data byte.
- cam_byte_valid  in  1  one-cycle strobe; cam_byte is valid this cycle.
- bin_thres  in  8  luma threshold.
- invert  in  1  invert the binarised output.
- capture_pixel  out  1  binarised pixel.
- capture_addr  out  ADDR_W  pixel address within the frame.
- capture_wren  out  1  one-cycle write strobe for pixel/addr.
- frame_done  out  1  one-cycle pulse at end of an armed frame.
- frame_error  out  1  last armed frame pixel count != FRAME_SIZE.
- luma_out  out  8  luma of the last emitted pixel (debug).

Behaviour:
- Reset: all outputs 0; armed=0; byte phase=0; pixel count=0; pipeline valids=0. Reset mid-frame abandons the frame; no writes occur until re-armed.
- Frame boundary = vsync rising edge, detected against a registered copy of vsync:
  - armed <= enable.
  - Pixel count and byte phase cleared.
  - If the block was armed for the frame just ended, frame_done pulses 2 cycles later, after the pipeline drains, so it follows the last wren.
  - At that pulse, frame_error <= (count != FRAME_SIZE); otherwise frame_error holds.
- Asserting or deasserting enable mid-frame has no effect until the next vsync rise; frames are always whole.
- Byte accept: cam_byte_valid && cam_href && !cam_vsync && armed. The phase toggles on each accepted byte.
  - Phase 0 byte = {R[4:0],G[5:3]}.
  - Phase 1 byte = {G[2:0],B[4:0]}; completes a pixel.
- Falling edge of href forces phase 0; a dangling odd byte is discarded.
- Throughput: bytes may arrive on consecutive cycles, giving at most 1 pixel per 2 cycles; no backpressure.
- Stage 1 (cycle after the phase-1 byte):
  - Expand to 8 bits by bit replication: R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}.
  - Register the products 77*R8, 150*G8, 29*B8.
- Stage 2:
  - luma = (sum)>>8. Sum is 16 bits, max 65280, so luma ≤ 255 with no overflow.
  - capture_pixel = (luma >= bin_thres) ^ invert.
  - capture_addr = pixel count at assembly.
  - luma_out = luma.
- Write strobe: capture_wren=1 for one cycle if count < FRAME_SIZE.
  - Latency: wren rises exactly 2 cycles after the edge that samples the phase-1 byte.
- Pixel counter: increments per assembled pixel and saturates at 2^ADDR_W-1. Pixels at count ≥ FRAME_SIZE are dropped (no wren) but still counted, so overflow is flagged.
- bin_thres and invert are sampled in stage 2; changes take effect on the next emitted pixel.
- Simultaneous vsync rise and phase-1 byte: the byte is rejected (vsync high), and the pipeline contents still drain.

Decomposition:
- Shared package holds:
  - FRAME_SIZE, ADDR_W.
  - Luma coefficients 77/150/29 and shift 8.
  - RGB565 field positions.
- One sub-module, rgb565_luma_pipe: the 2-stage expand/multiply/sum pipeline with a valid in/out.
- Framing, counter, threshold and status logic stay in the top.

Test Plan:
- Reset, enable=1, one dummy vsync pulse, then a 320x240 frame of bytes 0xFF with bin_thres=128.
  - Expect 76800 wren pulses, addr 0..76799 in order, pixel=1.
  - Expect one frame_done after the last wren, frame_error=0.
- Pixel 0xF800 (pure red): luma_out=76.
  - bin_thres=76 -> pixel 1; bin_thres=77 -> pixel 0.
  - invert=1 flips both results.
- Pixel 0x0000 with bin_thres=0 -> pixel 1; bin_thres=1 -> pixel 0.
  - Check wren is 2 cycles after the second byte with back-to-back byte strobes.
- Short frame of 100 pixels -> frame_done, frame_error=1.
  - Frame of 76801 pixels -> exactly 76800 wren, frame_error=1.
  - Following correct frame -> frame_error=0.
- enable dropped mid-frame -> the current frame completes all writes, and the next frame produces no wren or frame_done.
  - enable raised mid-frame -> no writes until after the next vsync rise.
- Line with href falling after 3 bytes -> exactly 1 pixel emitted; the next line's first byte is treated as phase 0.
  - reset asserted mid-frame -> outputs 0 and no wren until re-armed at a vsync rise.
